// File: rtl/asyncf_rd_stream.sv
// Purpose : read-domain consumer of the async FIFO; pops the read port and presents words on a valid/ready stream.
// Latency : rinc in cycle N, rdata captured at end of N+1, m_valid/m_data in N+2; sustains 1 word/cycle.
// Backpressure: 2-entry skid buffer; pops are credit-limited so buffered + in-flight words never exceed 2.
module asyncf_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CSIZE = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [CSIZE-1:0] beat_cnt
);

    // Buffer occupancy doubles as the FSM state; encoding equals the word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic             infl_q, infl_d;     // a pop was issued last cycle: rdata is live now
    logic             head_q, head_d;     // slot index presented on m_data
    logic [DSIZE-1:0] mem0_q, mem0_d;
    logic [DSIZE-1:0] mem1_q, mem1_d;
    logic [CSIZE-1:0] beat_q, beat_d;

    logic       fire;
    logic       cap;
    logic       tail;
    logic [1:0] occ_cnt;
    logic [2:0] pending;
    logic       room;

    // Stream side and pop credit: a pop is allowed only if, after this cycle's
    // fire, the words buffered plus the one in flight leave a free slot for it.
    always_comb begin
        occ_cnt = occ_q;
        m_valid = (occ_q != EMPTY);
        m_data  = head_q ? mem1_q : mem0_q;
        fire    = m_valid & m_ready;
        cap     = infl_q;
        pending = {1'b0, occ_cnt} + {2'b00, infl_q};
        room    = (pending < (3'd2 + {2'b00, fire}));
        rinc    = rrst_n & en & ~rempty & room;
    end

    // Occupancy FSM: capture adds a word, fire removes one, both together hold.
    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            EMPTY: begin
                if (cap) occ_d = ONE;
            end
            ONE: begin
                if (cap && !fire)      occ_d = TWO;
                else if (!cap && fire) occ_d = EMPTY;
            end
            TWO: begin
                if (fire && !cap) occ_d = ONE;
            end
            default: occ_d = EMPTY;
        endcase
    end

    // Datapath next state: tail slot is head + occupancy (mod 2); the head slot
    // is never overwritten while valid, so m_data holds steady until fire.
    always_comb begin
        tail   = head_q ^ occ_cnt[0];
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        if (cap && !tail) mem0_d = rdata;
        if (cap &&  tail) mem1_d = rdata;
        head_d = head_q ^ fire;
        infl_d = rinc;
        beat_d = beat_q + CSIZE'(fire);
    end

    // State registers with synchronous active-low reset; in-flight and buffered words are discarded.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            occ_q  <= EMPTY;
            infl_q <= 1'b0;
            head_q <= 1'b0;
            mem0_q <= '0;
            mem1_q <= '0;
            beat_q <= '0;
        end else begin
            occ_q  <= occ_d;
            infl_q <= infl_d;
            head_q <= head_d;
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            beat_q <= beat_d;
        end
    end

    assign beat_cnt = beat_q;

endmodule

// File: tb/tb_asyncf_rd_stream.sv
// Purpose : directed bench for asyncf_rd_stream with a behavioural FIFO read port model.
// Latency : model returns rdata one cycle after a sampled rinc, as the real FIFO does.
// Backpressure: m_ready driven directly per scenario; a CSIZE=4 twin checks counter wrap.
module tb_asyncf_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst_n, en, rempty, m_ready;
    logic [7:0] rdata;
    logic       rinc, m_valid;
    logic [7:0] m_data;
    logic [15:0] beat_cnt;
    logic       rinc4, m_valid4;
    logic [7:0] m_data4;
    logic [3:0] beat_cnt4;

    always #5 rclk = ~rclk;

    asyncf_rd_stream #(.DSIZE(8), .CSIZE(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .beat_cnt(beat_cnt)
    );

    asyncf_rd_stream #(.DSIZE(8), .CSIZE(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .beat_cnt(beat_cnt4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, pops = 0, first_rinc = -1, first_vld = -1, fire_first = -1, fire_last = -1;
    logic [7:0] fifo_q[$];
    logic [7:0] out_q[$];
    logic       vld_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
        rempty = (fifo_q.size() == 0);
    endtask

    // One clock: sample outputs before the edge, advance, then update the FIFO model.
    task automatic tick();
        logic       rinc_s, vld_s, fire_s, rst_s;
        logic [7:0] dat_s;
        #1;
        rinc_s = rinc;
        vld_s  = m_valid;
        fire_s = m_valid & m_ready;
        dat_s  = m_data;
        rst_s  = rrst_n;
        if (vld_prev) chk("hold_data", dat_s, data_prev);
        chk("rinc_while_empty", rinc_s & rempty, 0);
        vld_prev  = rst_s & vld_s & ~m_ready;
        data_prev = dat_s;
        if (fire_s === 1'b1) begin
            out_q.push_back(dat_s);
            if (fire_first < 0) fire_first = cyc;
            fire_last = cyc;
        end
        if (rinc_s === 1'b1) begin
            pops++;
            if (first_rinc < 0) first_rinc = cyc;
        end
        @(posedge rclk);
        #1;
        if (rinc_s === 1'b1 && fifo_q.size() > 0) rdata = fifo_q.pop_front();
        rempty = (fifo_q.size() == 0);
        cyc++;
        chk("occ2_infl_unreachable", (dut.occ_q == 2'd2) && dut.infl_q, 0);
    endtask

    task automatic drain(input int n, input int budget);
        for (int t = 0; t < budget && out_q.size() < n; t++) tick();
    endtask

    initial begin
        rrst_n = 1'b0; en = 1'b1; m_ready = 1'b1; rdata = 8'h00; rempty = 1'b1;

        // Reset held 3 cycles with a non-empty FIFO.
        fifo_load(8'h01, 16);
        repeat (3) begin
            tick();
            chk("rst_rinc", rinc, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_beat", beat_cnt, 0);
        end
        chk("rst_pops", pops, 0);
        chk("rst_data", m_data, 0);

        // Streaming 0x01..0x10 at full rate.
        rrst_n = 1'b1; out_q.delete(); first_rinc = -1; fire_first = -1; first_vld = -1;
        for (int t = 0; t < 60 && out_q.size() < 16; t++) begin
            tick();
            if (m_valid === 1'b1 && first_vld < 0) first_vld = cyc;
        end
        chk("stream_count", out_q.size(), 16);
        for (int i = 0; i < out_q.size(); i++) chk("stream_word", out_q[i], i + 1);
        chk("stream_latency", first_vld - first_rinc, 2);
        chk("stream_back_to_back", fire_last - fire_first, 15);
        chk("stream_beat", beat_cnt, 16);
        chk("stream_beat4", beat_cnt4, 0);
        chk("stream_valid_after", m_valid, 0);

        // Back-pressure from empty: only two words accepted, head held.
        m_ready = 1'b0; pops = 0; out_q.delete();
        fifo_load(8'h20, 16);
        repeat (10) tick();
        chk("bp_pops", pops, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, 8'h20);
        m_ready = 1'b1;
        #1;
        chk("bp_resume_rinc", rinc, 1);
        drain(16, 60);
        chk("bp_count", out_q.size(), 16);
        for (int i = 0; i < out_q.size(); i++) chk("bp_word", out_q[i], 32'h20 + i);
        chk("bp_beat", beat_cnt, 32);

        // Single word, FIFO runs empty.
        pops = 0; out_q.delete();
        fifo_load(8'hA5, 1);
        repeat (8) tick();
        chk("one_pops", pops, 1);
        chk("one_count", out_q.size(), 1);
        if (out_q.size() > 0) chk("one_word", out_q[0], 8'hA5);
        chk("one_valid_after", m_valid, 0);
        chk("one_rinc_after", rinc, 0);

        // Enable gating with one word buffered and one in flight.
        pops = 0; out_q.delete();
        fifo_load(8'h30, 8);
        repeat (2) tick();
        chk("en_pre_state", {dut.occ_q, dut.infl_q}, 3'b011);
        en = 1'b0;
        #1;
        chk("en_rinc_now", rinc, 0);
        pops = 0;
        repeat (6) tick();
        chk("en_pops", pops, 0);
        chk("en_drained", out_q.size(), 2);
        if (out_q.size() == 2) begin
            chk("en_word0", out_q[0], 8'h30);
            chk("en_word1", out_q[1], 8'h31);
        end
        chk("en_valid_after", m_valid, 0);
        en = 1'b1;
        drain(8, 40);
        chk("en_count", out_q.size(), 8);
        for (int i = 0; i < out_q.size(); i++) chk("en_word", out_q[i], 32'h30 + i);

        // Mid-operation reset with two words buffered.
        m_ready = 1'b0;
        fifo_load(8'h60, 4);
        repeat (5) tick();
        chk("mrst_pre_occ", dut.occ_q, 2);
        rrst_n = 1'b0; fifo_q.delete(); rempty = 1'b1;
        #1;
        chk("mrst_rinc_comb", rinc, 0);
        tick();
        chk("mrst_valid", m_valid, 0);
        chk("mrst_data", m_data, 0);
        chk("mrst_beat", beat_cnt, 0);
        chk("mrst_valid4", m_valid4, 0);
        chk("mrst_data4", m_data4, 0);
        chk("mrst_beat4", beat_cnt4, 0);
        chk("mrst_rinc4", rinc4, 0);

        // Counter wrap: 17 beats on the 4-bit counter leaves 1.
        rrst_n = 1'b1; m_ready = 1'b1; out_q.delete();
        fifo_load(8'h40, 17);
        drain(17, 60);
        chk("wrap_count", out_q.size(), 17);
        for (int i = 0; i < out_q.size(); i++) chk("wrap_word", out_q[i], 32'h40 + i);
        chk("wrap_beat4", beat_cnt4, 1);
        chk("wrap_beat16", beat_cnt, 17);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
